limn2600_fetch: RTL and testbench

//  Instruction fetch stage directly upstream of limn2600_cache: sequences the PC, reads instruction words

---
 rtl/limn2600_pkg.sv | 24 ++
 rtl/limn2600_fetch_queue.sv | 70 +++++++
 rtl/limn2600_fetch.sv | 166 ++++++++++++++++
 tb/tb_limn2600_fetch.sv | 281 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/limn2600_pkg.sv
// Shared constants and types for the limn2600 instruction fetch front end.
package limn2600_pkg;

  localparam logic [31:0] RESET_VECTOR = 32'hFFFE_0000;
  localparam int          INST_WIDTH   = 32;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    DROP  = 2'd2
  } fetch_state_t;

  // One buffered fetch result: where it came from and what was read.
  typedef struct packed {
    logic [31:0]           pc;
    logic [INST_WIDTH-1:0] inst;
  } fetch_entry_t;

  // Instruction addresses are always word aligned; low two bits are dropped.
  function automatic logic [31:0] word_align(input logic [31:0] addr);
    return {addr[31:2], 2'b00};
  endfunction

endpackage

// File: rtl/limn2600_fetch_queue.sv
// Small synchronous FIFO of {pc, inst} pairs between fetch and decode.
// Push and pop may coincide at any occupancy; flush empties it in one edge.
module limn2600_fetch_queue
  import limn2600_pkg::*;
#(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  fetch_entry_t           push_entry,
  input  logic                   pop,
  input  logic                   flush,
  output logic                   head_valid,
  output fetch_entry_t           head_entry,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  fetch_entry_t     entries [DEPTH];
  logic [PTR_W-1:0] rd_ptr_reg;
  logic [PTR_W-1:0] wr_ptr_reg;
  logic [CNT_W-1:0] count_reg;
  logic             pop_ok;
  logic             push_ok;

  // A pop on an empty queue or a push into a full one without a pop is refused.
  assign pop_ok  = pop & (count_reg != '0);
  assign push_ok = push & ((count_reg != FULL_CNT) | pop_ok);

  // Entry storage; a flush suppresses the write so no stale word lands.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        entries[i] <= '0;
      end
    end else if (push_ok && !flush) begin
      entries[wr_ptr_reg] <= push_entry;
    end
  end

  // Pointers and occupancy; flush wins over any concurrent push or pop.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else if (flush) begin
      rd_ptr_reg <= '0;
      wr_ptr_reg <= '0;
      count_reg  <= '0;
    end else begin
      if (push_ok) begin
        wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
      end
      if (pop_ok) begin
        rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
      end
      count_reg <= count_reg + CNT_W'(push_ok) - CNT_W'(pop_ok);
    end
  end

  assign head_valid = (count_reg != '0);
  assign head_entry = entries[rd_ptr_reg];
  assign count      = count_reg;

endmodule

// File: rtl/limn2600_fetch.sv
// Instruction fetch stage: walks the PC, issues single-outstanding bus reads,
// mirrors every returned word into the cache write port and queues {pc, inst}
// for decode. Redirects flush the queue; a read already on the bus is allowed
// to finish (its cache write is still valid) but its result is discarded.
module limn2600_fetch
  import limn2600_pkg::*;
#(
  parameter logic [31:0] RESET_PC    = RESET_VECTOR,
  parameter int          QUEUE_DEPTH = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        bus_req,
  output logic [31:0] bus_addr,
  input  logic        bus_ack,
  input  logic [31:0] bus_data,
  output logic        cache_we,
  output logic [31:0] cache_addr_in,
  output logic [31:0] cache_data_in,
  output logic        inst_valid,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data,
  input  logic        inst_ready
);

  localparam int CNT_W = $clog2(QUEUE_DEPTH) + 1;
  localparam logic [CNT_W-1:0] DEPTH_CNT = CNT_W'(QUEUE_DEPTH);

  fetch_state_t     state_reg;
  fetch_state_t     state_next;
  logic [31:0]      pc_reg;
  logic [31:0]      drop_addr_reg;
  logic             cache_we_reg;
  logic [31:0]      cache_addr_reg;
  logic [31:0]      cache_data_reg;
  logic [CNT_W-1:0] q_count;
  logic [CNT_W-1:0] count_after;
  logic             ack_fetch;
  logic             ack_drop;
  logic             q_push;
  logic             q_pop;
  fetch_entry_t     push_entry;
  fetch_entry_t     head_entry;

  assign ack_fetch   = bus_ack & (state_reg == FETCH);
  assign ack_drop    = bus_ack & (state_reg == DROP);
  // A redirect flushes the queue, so neither the returning word nor decode's pop counts.
  assign q_push      = ack_fetch & ~redirect_valid;
  assign q_pop       = inst_valid & inst_ready & ~redirect_valid;
  // Occupancy after this edge's push (only consulted when a fetch completes).
  assign count_after = q_count + CNT_W'(1) - CNT_W'(q_pop);
  assign push_entry  = '{pc: pc_reg, inst: bus_data};

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  // Next state: only start a read when the queue has a slot reserved for its result.
  always_comb begin
    state_next = state_reg;
    unique case (state_reg)
      IDLE: begin
        if (!redirect_valid && (q_count < DEPTH_CNT)) begin
          state_next = FETCH;
        end
      end
      FETCH: begin
        if (redirect_valid) begin
          state_next = bus_ack ? IDLE : DROP;
        end else if (bus_ack) begin
          state_next = (count_after < DEPTH_CNT) ? FETCH : IDLE;
        end
      end
      DROP: begin
        if (bus_ack) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Bus outputs: DROP keeps presenting the abandoned address until it is acked.
  always_comb begin
    bus_req  = 1'b0;
    bus_addr = '0;
    unique case (state_reg)
      FETCH: begin
        bus_req  = 1'b1;
        bus_addr = pc_reg;
      end
      DROP: begin
        bus_req  = 1'b1;
        bus_addr = drop_addr_reg;
      end
      default: begin
        bus_req  = 1'b0;
        bus_addr = '0;
      end
    endcase
  end

  // Program counter: redirect has priority over sequential advance (wraps at 2^32).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_reg <= RESET_PC;
    end else if (redirect_valid) begin
      pc_reg <= word_align(redirect_pc);
    end else if (ack_fetch) begin
      pc_reg <= pc_reg + 32'd4;
    end
  end

  // Remember the in-flight address when a redirect abandons an unacked read.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      drop_addr_reg <= '0;
    end else if ((state_reg == FETCH) && redirect_valid && !bus_ack) begin
      drop_addr_reg <= pc_reg;
    end
  end

  // Cache write port: every completed read is written, dropped or not.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cache_we_reg   <= 1'b0;
      cache_addr_reg <= '0;
      cache_data_reg <= '0;
    end else begin
      cache_we_reg <= ack_fetch | ack_drop;
      if (ack_fetch || ack_drop) begin
        cache_addr_reg <= bus_addr;
        cache_data_reg <= bus_data;
      end
    end
  end

  assign cache_we      = cache_we_reg;
  assign cache_addr_in = cache_addr_reg;
  assign cache_data_in = cache_data_reg;

  limn2600_fetch_queue #(
    .DEPTH (QUEUE_DEPTH)
  ) u_queue (
    .clk        (clk),
    .rst        (rst),
    .push       (q_push),
    .push_entry (push_entry),
    .pop        (q_pop),
    .flush      (redirect_valid),
    .head_valid (inst_valid),
    .head_entry (head_entry),
    .count      (q_count)
  );

  assign inst_pc   = head_entry.pc;
  assign inst_data = head_entry.inst;

endmodule

// File: tb/tb_limn2600_fetch.sv
// Scoreboard bench for limn2600_fetch: a driver plays memory and redirect source
// and pushes expected cache writes / instructions; two monitors pop and compare.
module tb_limn2600_fetch;

  localparam int          QD    = 2;
  localparam logic [31:0] RESET = 32'hFFFE_0000;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        bus_req;
  logic [31:0] bus_addr;
  logic        bus_ack = 1'b0;
  logic [31:0] bus_data = '0;
  logic        cache_we;
  logic [31:0] cache_addr_in;
  logic [31:0] cache_data_in;
  logic        inst_valid;
  logic [31:0] inst_pc;
  logic [31:0] inst_data;
  logic        inst_ready = 1'b0;

  limn2600_fetch #(.RESET_PC(RESET), .QUEUE_DEPTH(QD)) dut (
    .clk(clk), .rst(rst),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .bus_req(bus_req), .bus_addr(bus_addr), .bus_ack(bus_ack), .bus_data(bus_data),
    .cache_we(cache_we), .cache_addr_in(cache_addr_in), .cache_data_in(cache_data_in),
    .inst_valid(inst_valid), .inst_pc(inst_pc), .inst_data(inst_data), .inst_ready(inst_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] a;
    logic [31:0] d;
  } pair_t;

  pair_t exp_inst[$];
  pair_t exp_cache[$];

  int n_checks = 0;
  int n_pass   = 0;

  // reference model state
  logic [31:0] exp_fetch;
  logic        req_active;
  logic        cur_stale;
  logic [31:0] cur_addr;
  int          wait_left;
  int          delay_lo, delay_hi, redir_pct;
  int          redir_age;
  int          n_live_acks;
  logic        snap_valid, snap_req, fired;
  logic [31:0] watch_addr;
  logic        watch_hit;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0], a[31:16]} ^ 32'h5A5A_C3C3;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h want %h", name, act, exp);
  endtask

  task automatic model_reset();
    exp_inst.delete();
    exp_cache.delete();
    exp_fetch  = RESET;
    req_active = 1'b0;
    cur_stale  = 1'b0;
    wait_left  = 0;
    redir_age  = 0;
  endtask

  // One bus cycle: observe at negedge, decide inputs for the next posedge, update model.
  task automatic step(input int ready_pct, input int mode, input logic [31:0] tgt);
    logic        do_ack, do_redir, rdy;
    logic [31:0] t;
    @(negedge clk);
    snap_valid = inst_valid;
    snap_req   = bus_req;
    if (redir_age == 1) begin
      chk("redir_gap", {31'd0, bus_req}, 32'd0);
      redir_age = 2;
    end else if (redir_age == 2) begin
      chk("redir_restart", {31'd0, bus_req}, 32'd1);
      redir_age = 0;
    end
    if (req_active) begin
      chk("req_held", {31'd0, bus_req}, 32'd1);
      if (bus_req) chk("addr_held", bus_addr, cur_addr);
    end else if (bus_req) begin
      chk("fetch_addr", bus_addr, exp_fetch);
      chk("slot_free", {31'd0, exp_inst.size() < QD}, 32'd1);
      if (bus_addr == watch_addr) watch_hit = 1'b1;
      req_active = 1'b1;
      cur_stale  = 1'b0;
      cur_addr   = exp_fetch;
      wait_left  = int'($urandom_range(delay_lo, delay_hi));
    end
    rdy    = (int'($urandom_range(0, 99)) < ready_pct);
    do_ack = req_active && (wait_left == 0);
    if (req_active && wait_left > 0) wait_left--;
    case (mode)
      1:       do_redir = (int'($urandom_range(0, 99)) < redir_pct);
      2:       do_redir = 1'b1;
      3:       do_redir = do_ack && inst_valid && rdy;
      default: do_redir = 1'b0;
    endcase
    t = tgt;
    if (mode == 1) t = ($urandom_range(0, 3) == 0) ? (32'hFFFF_FFF0 | $urandom_range(0, 15)) : $urandom();
    inst_ready     = rdy;
    bus_ack        = do_ack;
    bus_data       = do_ack ? mem_word(bus_addr) : $urandom();
    redirect_valid = do_redir;
    redirect_pc    = do_redir ? t : $urandom();
    if (do_ack) begin
      exp_cache.push_back('{a: cur_addr, d: mem_word(cur_addr)});
      if (!cur_stale && !do_redir) begin
        exp_inst.push_back('{a: cur_addr, d: mem_word(cur_addr)});
        exp_fetch = cur_addr + 32'd4;
        n_live_acks++;
      end
      req_active = 1'b0;
    end
    if (do_redir) begin
      exp_inst.delete();
      exp_fetch = {t[31:2], 2'b00};
      if (req_active) begin
        cur_stale = 1'b1;
        redir_age = 0;
      end else begin
        redir_age = 1;
      end
    end
    fired = do_redir;
  endtask

  // Instruction monitor: head must match the oldest expected live fetch.
  initial forever begin
    @(negedge clk);
    #1;
    if (rst && inst_valid && !redirect_valid) begin
      if (exp_inst.size() == 0) begin
        chk("inst_unexpected", inst_pc, 32'hXXXX_XXXX);
      end else begin
        chk("inst_pc", inst_pc, exp_inst[0].a);
        chk("inst_data", inst_data, exp_inst[0].d);
        if (inst_ready) begin
          $display("inst pc=%h data=%h", inst_pc, inst_data);
          void'(exp_inst.pop_front());
        end
      end
    end
  end

  // Cache monitor: every write strobe must match the oldest completed read.
  initial forever begin
    @(negedge clk);
    #1;
    if (cache_we) begin
      if (exp_cache.size() == 0) begin
        chk("cache_unexpected", cache_addr_in, 32'hXXXX_XXXX);
      end else begin
        $display("cache addr=%h data=%h", cache_addr_in, cache_data_in);
        chk("cache_addr", cache_addr_in, exp_cache[0].a);
        chk("cache_data", cache_data_in, exp_cache[0].d);
        void'(exp_cache.pop_front());
      end
    end
  end

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_req"}, {31'd0, bus_req}, 32'd0);
    chk({tag, "_bus_addr"}, bus_addr, 32'd0);
    chk({tag, "_cache_we"}, {31'd0, cache_we}, 32'd0);
    chk({tag, "_cache_addr"}, cache_addr_in, 32'd0);
    chk({tag, "_cache_data"}, cache_data_in, 32'd0);
    chk({tag, "_inst_valid"}, {31'd0, inst_valid}, 32'd0);
    chk({tag, "_inst_pc"}, inst_pc, 32'd0);
    chk({tag, "_inst_data"}, inst_data, 32'd0);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int base;
    model_reset();
    n_live_acks = 0;
    watch_addr  = 32'h0000_0003;
    watch_hit   = 1'b0;
    redir_pct   = 0;
    rst = 1'b1;
    #2 rst = 1'b0;
    repeat (3) @(negedge clk);
    #1 chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b1;

    // sequential fetch, ack one cycle after each request
    delay_lo = 1; delay_hi = 1;
    repeat (16) step(100, 0, 32'd0);

    // decode stalled: exactly QD results buffered, then bus goes quiet
    delay_lo = 0; delay_hi = 0;
    repeat (10) step(0, 0, 32'd0);
    chk("stall_req_off", {31'd0, snap_req}, 32'd0);
    chk("stall_buffered", exp_inst.size(), QD);
    repeat (10) step(100, 0, 32'd0);

    // asynchronous reset in the middle of a read
    delay_lo = 3; delay_hi = 3;
    for (int i = 0; i < 20 && !req_active; i++) step(100, 0, 32'd0);
    chk("rst_mid_pending", {31'd0, req_active}, 32'd1);
    @(posedge clk);
    #2 rst = 1'b0;
    #1 chk_all_zero("async_rst");
    bus_ack = 1'b0;
    redirect_valid = 1'b0;
    model_reset();
    repeat (2) @(negedge clk);
    rst      = 1'b1;
    bus_ack  = 1'b1;
    bus_data = 32'hDEAD_BEEF;

    // redirect while the third read after reset waits on a slow ack
    delay_lo = 0; delay_hi = 0;
    base = n_live_acks;
    for (int i = 0; i < 20 && n_live_acks < base + 2; i++) step(100, 0, 32'd0);
    chk("t3_two_acks", n_live_acks - base, 32'd2);
    delay_lo = 5; delay_hi = 5;
    step(100, 0, 32'd0);
    chk("t3_pending_addr", cur_addr, 32'hFFFE_0008);
    delay_lo = 0; delay_hi = 0;
    watch_addr = 32'h0000_1000;
    watch_hit  = 1'b0;
    step(100, 2, 32'h0000_1002);
    repeat (12) step(100, 0, 32'd0);
    chk("t3_restart_1000", {31'd0, watch_hit}, 32'd1);

    // redirect coinciding with an ack and a decode handshake
    fired = 1'b0;
    for (int i = 0; i < 30 && !fired; i++) step(100, 3, 32'h0000_2000);
    chk("t4_fired", {31'd0, fired}, 32'd1);
    watch_addr = 32'h0000_2000;
    watch_hit  = 1'b0;
    step(100, 0, 32'd0);
    chk("t4_flushed", {31'd0, snap_valid}, 32'd0);
    repeat (6) step(100, 0, 32'd0);
    chk("t4_restart", {31'd0, watch_hit}, 32'd1);

    // PC wrap at the top of the address space
    watch_addr = 32'h0000_0000;
    watch_hit  = 1'b0;
    step(100, 2, 32'hFFFF_FFFC);
    repeat (14) step(100, 0, 32'd0);
    chk("t5_wrap", {31'd0, watch_hit}, 32'd1);

    // randomized traffic
    delay_lo = 0; delay_hi = 3; redir_pct = 4;
    repeat (400) step(70, 1, 32'd0);

    // drain: stop answering new reads, let decode empty the queue
    delay_lo = 1000; delay_hi = 1000;
    repeat (12) step(100, 0, 32'd0);
    chk("drain_inst", exp_inst.size(), 32'd0);
    chk("drain_cache", exp_cache.size(), 32'd0);
    chk("progress", {31'd0, n_live_acks > 100}, 32'd1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
